memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
// - Memory-side responder to the CPU bus strobes driven by sequence control.
//   CPU strobes: MEM_En, MEM_Wr (both active-low), address, write data.
// - Before the CPU runs, a boot FSM fills the RAM from a byte stream.
//   Mem_Ready then signals that the CPU may be released.
// - Sits between the CPU address/data muxes and the IR/register-file load paths.
// PARAMETERS
// - DataWidth  16  bus word width; also the width of the Addr port
// - AddrWidth  9   RAM index width; Depth = 2**AddrWidth words
// PORTS
// - Clk         in   1          clock; all state changes on posedge
// - Reset       in   1          synchronous, active-low
// - MEM_En      in   1          0 = CPU access this cycle
// - MEM_Wr      in   1          0 = write, 1 = read; qualified by MEM_En=0
// - Addr        in   DataWidth  CPU word address
// - Data_In     in   DataWidth  CPU write data
// - Data_Out    out  DataWidth  registered read data
// - Boot_Valid  in   1          boot byte present
// - Boot_Data   in   8          boot byte; word = {first byte, second byte}
// - Boot_Last   in   1          qualifies the final boot byte
// - Boot_Ready  out  1          byte accepted on a cycle with Valid & Ready
// - Mem_Ready   out  1          boot complete; CPU accesses now serviced
// - Boot_Err    out  1          sticky boot-error flag
// - Addr_Err    out  1          1-cycle pulse: CPU address out of range
// BEHAVIOUR
// - Reset=0 at posedge:
//   - state <= S_BootHi; ptr <= 0; last_q <= 0.
//   - Data_Out <= 0; Mem_Ready, Boot_Err, Addr_Err <= 0.
//   - RAM contents are NOT cleared. Reset mid-boot restarts loading at address 0.
// - Boot_Ready = 1 only in S_BootHi and S_BootLo (combinational from state).
// - FSM states and transitions:
//   - S_BootHi: on Valid, hi <= Boot_Data.
//     If Boot_Last: Boot_Err <= 1, no write, go S_Serve (odd byte count).
//     Otherwise go S_BootLo.
//   - S_BootLo: on Valid, word <= {hi, Boot_Data}; last_q <= Boot_Last; go S_Write.
//   - S_Write: mem[ptr] <= word; ptr <= ptr+1.
//     If last_q: go S_Serve.
//     Else if ptr == Depth-1: Boot_Err <= 1, go S_Serve (overflow).
//     Else go S_BootHi.
//   - S_Serve: Mem_Ready = 1 (registered), held until Reset.
//     Boot_Valid is ignored; Boot_Ready = 0.
// - CPU access, S_Serve only; strobes sampled at posedge:
//   - MEM_En=0, MEM_Wr=1 (read): Data_Out <= mem[Addr], valid after that edge.
//     Read latency is 1 clock, so the consumer may load Data_Out on the next edge.
//   - MEM_En=0, MEM_Wr=0 (write): mem[Addr] <= Data_In. Data_Out holds.
//   - MEM_En=1: no access; Data_Out holds its last value.
//   - Range check: Addr[DataWidth-1:AddrWidth] != 0 means out of range.
//     Addr_Err pulses for 1 cycle; a read returns Data_Out <= 0; a write is dropped.
// - Strobes in any boot state are ignored: no RAM change, Data_Out and Addr_Err unchanged.
// - The RAM is single-port; boot writes and CPU accesses never overlap (disjoint states).
// STRUCTURE
// - Shared package (a09 constants): boot state encodings, BOOT_BYTE_W = 8,
//   and active-low strobe level constants shared with sequence control.
// - Sub-module sp_ram: single-port, synchronous write, registered read.
//   Written so it infers block RAM.
// - The top level holds the boot FSM, pointer, range check and the
//   boot/CPU port mux into sp_ram.
// TESTING
// 1. Boot bytes 12,34,AB,CD with Last on CD.
//    -> mem[0]=1234, mem[1]=ABCD, Mem_Ready=1, Boot_Err=0.
//    Then read Addr=0001 -> Data_Out=ABCD one edge after the strobe edge.
// 2. In S_Serve, write Addr=0005, Data_In=BEEF.
//    -> Data_Out unchanged on the write edge.
//    Then read 0005 -> Data_Out=BEEF.
// 3. Boot bytes 11,22,33 with Last on 33.
//    -> mem[0]=1122, mem[1] unchanged, Boot_Err=1, Mem_Ready=1.
// 4. AddrWidth=9: read Addr=0200.
//    -> Addr_Err high exactly 1 cycle, Data_Out=0.
//    Write Addr=0200, Data_In=FFFF -> mem[0] unchanged.
// 5. Boot one word 5A5A, then Reset=0 for 1 cycle, then boot word C3C3 with Last.
//    -> mem[0]=C3C3.
//    CPU read strobes during boot -> Data_Out stays 0.
// 6. AddrWidth=2: stream 8 bytes, no Last.
//    -> 4 words written, Boot_Err=1, Mem_Ready=1.
//    9th byte offered -> Boot_Ready=0.

Source files
------------

// File: rtl/memory_responder_pkg.sv
// Shared constants for the memory responder: boot FSM encodings, boot byte
// width and the active-low strobe levels used by sequence control.
package memory_responder_pkg;

  localparam int BOOT_BYTE_W = 8;

  // Strobe levels on the CPU bus (both strobes are active-low)
  localparam logic STROBE_ACTIVE = 1'b0;
  localparam logic WR_WRITE      = 1'b0;
  localparam logic WR_READ       = 1'b1;

  typedef enum logic [1:0] {
    S_BootHi = 2'd0,
    S_BootLo = 2'd1,
    S_Write  = 2'd2,
    S_Serve  = 2'd3
  } boot_state_e;

endpackage : memory_responder_pkg

// File: rtl/memory_responder_if.sv
// CPU strobe bus plus boot byte stream between the system and the memory
// responder. The master side is the CPU / boot loader, the slave side is
// the responder.
interface memory_responder_if
  import memory_responder_pkg::*;
#(
  parameter int DataWidth = 16
);

  logic                   MEM_En;
  logic                   MEM_Wr;
  logic [DataWidth-1:0]   Addr;
  logic [DataWidth-1:0]   Data_In;
  logic [DataWidth-1:0]   Data_Out;
  logic                   Boot_Valid;
  logic [BOOT_BYTE_W-1:0] Boot_Data;
  logic                   Boot_Last;
  logic                   Boot_Ready;
  logic                   Mem_Ready;
  logic                   Boot_Err;
  logic                   Addr_Err;

  modport master (
    output MEM_En, MEM_Wr, Addr, Data_In, Boot_Valid, Boot_Data, Boot_Last,
    input  Data_Out, Boot_Ready, Mem_Ready, Boot_Err, Addr_Err
  );

  modport slave (
    input  MEM_En, MEM_Wr, Addr, Data_In, Boot_Valid, Boot_Data, Boot_Last,
    output Data_Out, Boot_Ready, Mem_Ready, Boot_Err, Addr_Err
  );

endinterface : memory_responder_if

// File: rtl/memory_responder_sp_ram.sv
// Single-port RAM: synchronous write, registered read. The read register
// carries a synchronous reset and a clear so it can act directly as the
// responder's Data_Out register.
module sp_ram #(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 9
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 we,
  input  logic                 re,
  input  logic                 clr,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  localparam int Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_r [Depth];
  logic [DataWidth-1:0] rdata_r;

  // Write port: contents are never reset
  always_ff @(posedge Clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

  // Read register: cleared by reset or clr, loaded on re, otherwise holds
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      rdata_r <= {DataWidth{1'b0}};
    end else if (clr) begin
      rdata_r <= {DataWidth{1'b0}};
    end else if (re) begin
      rdata_r <= mem_r[addr];
    end
  end

  assign rdata = rdata_r;

endmodule : sp_ram

// File: rtl/memory_responder.sv
// Memory-side responder: a boot FSM fills the RAM from a byte stream, then
// CPU read/write strobes are serviced with a 1-clock read latency and an
// address range check.
module memory_responder
  import memory_responder_pkg::*;
#(
  parameter int DataWidth = 16,
  parameter int AddrWidth = 9
) (
  input logic               Clk,
  input logic               Reset,
  memory_responder_if.slave bus
);

  localparam int Depth = 2 ** AddrWidth;
  localparam logic [AddrWidth-1:0] PtrLast = AddrWidth'(Depth - 1);
  localparam logic [AddrWidth-1:0] PtrOne  = AddrWidth'(1);

  boot_state_e                state_r;
  boot_state_e                state_s;
  logic [AddrWidth-1:0]       ptr_r;
  logic [BOOT_BYTE_W-1:0]     hi_r;
  logic [2*BOOT_BYTE_W-1:0]   word_r;
  logic                       last_q_r;
  logic                       mem_ready_r;
  logic                       boot_err_r;
  logic                       addr_err_r;

  logic                       boot_ready_s;
  logic                       cpu_en_s;
  logic                       cpu_read_s;
  logic                       out_of_range_s;
  logic                       ram_we_s;
  logic                       ram_re_s;
  logic                       ram_clr_s;
  logic [AddrWidth-1:0]       ram_addr_s;
  logic [DataWidth-1:0]       ram_wdata_s;
  logic [DataWidth-1:0]       ram_rdata_s;

  assign cpu_en_s       = (bus.MEM_En == STROBE_ACTIVE);
  assign cpu_read_s     = (bus.MEM_Wr == WR_READ);
  assign out_of_range_s = |bus.Addr[DataWidth-1:AddrWidth];

  // Boot FSM state register
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_r <= S_BootHi;
    end else begin
      state_r <= state_s;
    end
  end

  // Boot FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_BootHi: begin
        if (bus.Boot_Valid) begin
          if (bus.Boot_Last) begin
            state_s = S_Serve;
          end else begin
            state_s = S_BootLo;
          end
        end else begin
          state_s = S_BootHi;
        end
      end
      S_BootLo: begin
        if (bus.Boot_Valid) begin
          state_s = S_Write;
        end else begin
          state_s = S_BootLo;
        end
      end
      S_Write: begin
        if (last_q_r) begin
          state_s = S_Serve;
        end else if (ptr_r == PtrLast) begin
          state_s = S_Serve;
        end else begin
          state_s = S_BootHi;
        end
      end
      S_Serve: state_s = S_Serve;
      default: state_s = S_BootHi;
    endcase
  end

  // Output / RAM port mux: boot writes in S_Write, CPU accesses in S_Serve
  always_comb begin
    boot_ready_s = 1'b0;
    ram_we_s     = 1'b0;
    ram_re_s     = 1'b0;
    ram_clr_s    = 1'b0;
    ram_addr_s   = ptr_r;
    ram_wdata_s  = DataWidth'(word_r);
    case (state_r)
      S_BootHi, S_BootLo: boot_ready_s = 1'b1;
      S_Write:            ram_we_s     = 1'b1;
      S_Serve: begin
        ram_addr_s  = bus.Addr[AddrWidth-1:0];
        ram_wdata_s = bus.Data_In;
        if (cpu_en_s) begin
          if (out_of_range_s) begin
            // Out-of-range read returns zero, out-of-range write is dropped
            ram_clr_s = cpu_read_s;
          end else begin
            ram_we_s = !cpu_read_s;
            ram_re_s = cpu_read_s;
          end
        end else begin
          ram_we_s = 1'b0;
        end
      end
      default: boot_ready_s = 1'b0;
    endcase
  end

  // Boot datapath and status flags
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ptr_r       <= {AddrWidth{1'b0}};
      hi_r        <= {BOOT_BYTE_W{1'b0}};
      word_r      <= {(2*BOOT_BYTE_W){1'b0}};
      last_q_r    <= 1'b0;
      mem_ready_r <= 1'b0;
      boot_err_r  <= 1'b0;
      addr_err_r  <= 1'b0;
    end else begin
      case (state_r)
        S_BootHi: begin
          if (bus.Boot_Valid) begin
            hi_r <= bus.Boot_Data;
            if (bus.Boot_Last) begin
              // Odd byte count: the half word is discarded
              boot_err_r <= 1'b1;
            end
          end
        end
        S_BootLo: begin
          if (bus.Boot_Valid) begin
            word_r   <= {hi_r, bus.Boot_Data};
            last_q_r <= bus.Boot_Last;
          end
        end
        S_Write: begin
          ptr_r <= ptr_r + PtrOne;
          if (!last_q_r && (ptr_r == PtrLast)) begin
            // Stream longer than the RAM
            boot_err_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
      mem_ready_r <= (state_s == S_Serve);
      addr_err_r  <= (state_r == S_Serve) && cpu_en_s && out_of_range_s;
    end
  end

  sp_ram #(
    .DataWidth (DataWidth),
    .AddrWidth (AddrWidth)
  ) u_ram (
    .Clk   (Clk),
    .Reset (Reset),
    .we    (ram_we_s),
    .re    (ram_re_s),
    .clr   (ram_clr_s),
    .addr  (ram_addr_s),
    .wdata (ram_wdata_s),
    .rdata (ram_rdata_s)
  );

  assign bus.Data_Out   = ram_rdata_s;
  assign bus.Boot_Ready = boot_ready_s;
  assign bus.Mem_Ready  = mem_ready_r;
  assign bus.Boot_Err   = boot_err_r;
  assign bus.Addr_Err   = addr_err_r;

endmodule : memory_responder

// File: tb/tb_memory_responder.sv
// Directed bench for memory_responder: a 512-word instance (u9) and a
// 4-word instance (u2) share the CPU strobes; each has its own Boot_Valid.
module tb_memory_responder;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        mem_en = 1'b1;
  logic        mem_wr = 1'b1;
  logic [15:0] addr = 16'h0000;
  logic [15:0] data_in = 16'h0000;
  logic [7:0]  boot_data = 8'h00;
  logic        boot_last = 1'b0;
  logic        bv9 = 1'b0;
  logic        bv2 = 1'b0;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  always #5 Clk = ~Clk;

  memory_responder_if #(.DataWidth(16)) if9 ();
  memory_responder_if #(.DataWidth(16)) if2 ();

  assign if9.MEM_En = mem_en;     assign if2.MEM_En = mem_en;
  assign if9.MEM_Wr = mem_wr;     assign if2.MEM_Wr = mem_wr;
  assign if9.Addr = addr;         assign if2.Addr = addr;
  assign if9.Data_In = data_in;   assign if2.Data_In = data_in;
  assign if9.Boot_Data = boot_data; assign if2.Boot_Data = boot_data;
  assign if9.Boot_Last = boot_last; assign if2.Boot_Last = boot_last;
  assign if9.Boot_Valid = bv9;    assign if2.Boot_Valid = bv2;

  memory_responder #(.DataWidth(16), .AddrWidth(9)) u9 (
    .Clk(Clk), .Reset(Reset), .bus(if9.slave));
  memory_responder #(.DataWidth(16), .AddrWidth(2)) u2 (
    .Clk(Clk), .Reset(Reset), .bus(if2.slave));

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] dout(input bit sel);
    return sel ? if2.Data_Out : if9.Data_Out;
  endfunction

  function automatic logic rdy(input bit sel);
    return sel ? if2.Boot_Ready : if9.Boot_Ready;
  endfunction

  function automatic logic mrdy(input bit sel);
    return sel ? if2.Mem_Ready : if9.Mem_Ready;
  endfunction

  function automatic logic aerr(input bit sel);
    return sel ? if2.Addr_Err : if9.Addr_Err;
  endfunction

  // Offer one boot byte once Boot_Ready is seen (bounded wait)
  task automatic boot_byte(input bit sel, input logic [7:0] b, input logic last);
    int n = 0;
    while (!rdy(sel) && n < 20) begin
      tick();
      n++;
    end
    check("boot_ready_wait", {15'd0, rdy(sel)}, 16'd1);
    boot_data = b;
    boot_last = last;
    if (sel) bv2 = 1'b1; else bv9 = 1'b1;
    tick();
    bv9 = 1'b0;
    bv2 = 1'b0;
    boot_last = 1'b0;
  endtask

  task automatic wait_mem_ready(input bit sel);
    int n = 0;
    while (!mrdy(sel) && n < 20) begin
      tick();
      n++;
    end
    check("mem_ready_wait", {15'd0, mrdy(sel)}, 16'd1);
  endtask

  // CPU read: expected value queued at strobe time, compared after the edge
  task automatic cpu_read(input bit sel, input logic [15:0] a, input logic [15:0] exp,
                          input logic exp_err);
    logic [15:0] e;
    exp_q.push_back(exp);
    mem_en = 1'b0;
    mem_wr = 1'b1;
    addr = a;
    tick();
    mem_en = 1'b1;
    e = exp_q.pop_front();
    check($sformatf("read_%h", a), dout(sel), e);
    check($sformatf("addr_err_%h", a), {15'd0, aerr(sel)}, {15'd0, exp_err});
  endtask

  task automatic cpu_write(input logic [15:0] a, input logic [15:0] d);
    mem_en = 1'b0;
    mem_wr = 1'b0;
    addr = a;
    data_in = d;
    tick();
    mem_en = 1'b1;
    mem_wr = 1'b1;
  endtask

  initial begin
    // Reset state
    tick();
    tick();
    check("rst_dout", if9.Data_Out, 16'h0000);
    check("rst_mem_ready", {15'd0, if9.Mem_Ready}, 16'd0);
    check("rst_boot_err", {15'd0, if9.Boot_Err}, 16'd0);
    check("rst_addr_err", {15'd0, if9.Addr_Err}, 16'd0);
    check("rst_boot_ready", {15'd0, if9.Boot_Ready}, 16'd1);
    Reset = 1'b1;

    // 1: two-word boot, then read back
    boot_byte(1'b0, 8'h12, 1'b0);
    boot_byte(1'b0, 8'h34, 1'b0);
    boot_byte(1'b0, 8'hAB, 1'b0);
    boot_byte(1'b0, 8'hCD, 1'b1);
    wait_mem_ready(1'b0);
    check("t1_boot_err", {15'd0, if9.Boot_Err}, 16'd0);
    check("t1_boot_ready", {15'd0, if9.Boot_Ready}, 16'd0);
    cpu_read(1'b0, 16'h0001, 16'hABCD, 1'b0);
    cpu_read(1'b0, 16'h0000, 16'h1234, 1'b0);
    cpu_read(1'b0, 16'h0001, 16'hABCD, 1'b0);

    // 2: write holds Data_Out, then read it back
    cpu_write(16'h0005, 16'hBEEF);
    check("t2_write_hold", if9.Data_Out, 16'hABCD);
    check("t2_write_aerr", {15'd0, if9.Addr_Err}, 16'd0);
    tick();
    check("t2_idle_hold", if9.Data_Out, 16'hABCD);
    cpu_read(1'b0, 16'h0005, 16'hBEEF, 1'b0);

    // 3: odd byte count
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    check("t3_rst_dout", if9.Data_Out, 16'h0000);
    check("t3_rst_mem_ready", {15'd0, if9.Mem_Ready}, 16'd0);
    boot_byte(1'b0, 8'h11, 1'b0);
    boot_byte(1'b0, 8'h22, 1'b0);
    boot_byte(1'b0, 8'h33, 1'b1);
    wait_mem_ready(1'b0);
    check("t3_boot_err", {15'd0, if9.Boot_Err}, 16'd1);
    cpu_read(1'b0, 16'h0000, 16'h1122, 1'b0);
    cpu_read(1'b0, 16'h0001, 16'hABCD, 1'b0);
    cpu_read(1'b0, 16'h0005, 16'hBEEF, 1'b0);

    // 4: out-of-range read and write
    cpu_read(1'b0, 16'h0200, 16'h0000, 1'b1);
    tick();
    check("t4_aerr_pulse", {15'd0, if9.Addr_Err}, 16'd0);
    cpu_write(16'h0200, 16'hFFFF);
    check("t4_wr_aerr", {15'd0, if9.Addr_Err}, 16'd1);
    check("t4_wr_dout", if9.Data_Out, 16'h0000);
    tick();
    check("t4_wr_aerr_drop", {15'd0, if9.Addr_Err}, 16'd0);
    cpu_read(1'b0, 16'h0000, 16'h1122, 1'b0);

    // 5: reset mid-boot restarts at address 0; strobes ignored during boot
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    mem_en = 1'b0;
    mem_wr = 1'b1;
    addr = 16'h0001;
    boot_byte(1'b0, 8'h5A, 1'b0);
    check("t5_boot_dout_a", if9.Data_Out, 16'h0000);
    addr = 16'h0200;
    boot_byte(1'b0, 8'h5A, 1'b0);
    tick();
    check("t5_boot_dout_b", if9.Data_Out, 16'h0000);
    check("t5_boot_aerr", {15'd0, if9.Addr_Err}, 16'd0);
    check("t5_boot_mem_ready", {15'd0, if9.Mem_Ready}, 16'd0);
    mem_en = 1'b1;
    Reset = 1'b0;
    tick();
    Reset = 1'b1;
    boot_byte(1'b0, 8'hC3, 1'b0);
    boot_byte(1'b0, 8'hC3, 1'b1);
    wait_mem_ready(1'b0);
    check("t5_boot_err", {15'd0, if9.Boot_Err}, 16'd0);
    cpu_read(1'b0, 16'h0000, 16'hC3C3, 1'b0);
    cpu_read(1'b0, 16'h0001, 16'hABCD, 1'b0);

    // 6: 4-word RAM overflow
    for (int i = 0; i < 8; i++) begin
      boot_byte(1'b1, 8'(i + 1), 1'b0);
    end
    wait_mem_ready(1'b1);
    check("t6_boot_err", {15'd0, if2.Boot_Err}, 16'd1);
    check("t6_boot_ready", {15'd0, if2.Boot_Ready}, 16'd0);
    boot_data = 8'h09;
    bv2 = 1'b1;
    tick();
    check("t6_ninth_ready", {15'd0, if2.Boot_Ready}, 16'd0);
    check("t6_ninth_mem_ready", {15'd0, if2.Mem_Ready}, 16'd1);
    bv2 = 1'b0;
    cpu_read(1'b1, 16'h0000, 16'h0102, 1'b0);
    cpu_read(1'b1, 16'h0001, 16'h0304, 1'b0);
    cpu_read(1'b1, 16'h0002, 16'h0506, 1'b0);
    cpu_read(1'b1, 16'h0003, 16'h0708, 1'b0);
    cpu_read(1'b1, 16'h0004, 16'h0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_memory_responder
